vector_load_unit: RTL and testbench

Upstream feeder of the 128-bit, 16-entry vector register file. On a start command it fetches up to four 32-bit words from data memory, one outstanding request at a time, and writes each word into the selected 32-bit lane of the destination vector register using the register file's lane-write path (mem_load_enable). It reports completion with a one-cycle done pulse and holds busy for the whole transfer.

---
 rtl/vlu_pkg.sv | 27 ++
 rtl/vector_load_unit_next_lane_pick.sv | 32 +++
 rtl/vector_load_unit.sv | 138 +++++++++++++
 tb/tb_vector_load_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlu_pkg.sv
// -----------------------------------------------------------------------------
// vlu_pkg
// Shared definitions for the vector load unit: lane geometry, the FSM state
// encoding and a helper that forms the byte address of a lane.
// -----------------------------------------------------------------------------
package vlu_pkg;

   localparam int NUM_LANES  = 4;
   localparam int LANE_W     = 32;
   localparam int VREG_W     = NUM_LANES * LANE_W;
   localparam int LANE_IDX_W = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Byte address of a lane: base + 4*lane, wrapping modulo 2^32.
   function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                             input logic [LANE_IDX_W-1:0] lane);
      return base + {{(32-LANE_IDX_W-2){1'b0}}, lane, 2'b00};
   endfunction

endpackage

// File: rtl/vector_load_unit_next_lane_pick.sv
// -----------------------------------------------------------------------------
// next_lane_pick
// Combinational search for the next lane to load.
//   mask      : lanes still requested by the transfer
//   lane      : lane just completed (ignored when first=1)
//   first     : 1 = search from lane 0 inclusive, 0 = search above lane
//   next_lane : lowest qualifying set lane
//   valid     : 1 when a qualifying lane exists, 0 when none remain
// -----------------------------------------------------------------------------
module next_lane_pick
   import vlu_pkg::*;
(
   input  logic [NUM_LANES-1:0]  mask,
   input  logic [LANE_IDX_W-1:0] lane,
   input  logic                  first,
   output logic [LANE_IDX_W-1:0] next_lane,
   output logic                  valid
);

   // Scan from the top down so the lowest qualifying lane is the last one kept.
   always_comb begin
      next_lane = '0;
      valid     = 1'b0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (mask[i] && (first || (i > int'(lane)))) begin
            next_lane = LANE_IDX_W'(i);
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vector_load_unit.sv
// -----------------------------------------------------------------------------
// vector_load_unit
// Fetches up to four 32-bit words from data memory (one outstanding request)
// and writes each into its lane of a destination vector register via the
// register file's lane-write path.
// Ports:
//   clk, reset (sync, active-low)
//   start, base_addr, dest_reg, lane_mask   : command, sampled in IDLE
//   mem_req, mem_addr, mem_ready            : request handshake
//   mem_rvalid, mem_rdata                   : read response
//   rf_write_enable, rf_mem_load_enable,
//   rf_write_address_r, rf_write_address_c,
//   rf_write_data                           : register file lane write
//   busy, done                              : status
// -----------------------------------------------------------------------------
module vector_load_unit
   import vlu_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [31:0]           base_addr,
   input  logic [3:0]            dest_reg,
   input  logic [NUM_LANES-1:0]  lane_mask,
   output logic                  mem_req,
   output logic [31:0]           mem_addr,
   input  logic                  mem_ready,
   input  logic                  mem_rvalid,
   input  logic [LANE_W-1:0]     mem_rdata,
   output logic                  rf_write_enable,
   output logic                  rf_mem_load_enable,
   output logic [3:0]            rf_write_address_r,
   output logic [LANE_IDX_W-1:0] rf_write_address_c,
   output logic [VREG_W-1:0]     rf_write_data,
   output logic                  busy,
   output logic                  done
);

   state_t                  state_q, state_d;
   logic [31:0]             base_q;
   logic [3:0]              dest_q;
   logic [NUM_LANES-1:0]    mask_q;
   logic [LANE_IDX_W-1:0]   lane_q;
   logic [LANE_W-1:0]       data_q;

   logic [NUM_LANES-1:0]    pick_mask;
   logic                    pick_first;
   logic [LANE_IDX_W-1:0]   pick_lane;
   logic                    pick_valid;

   // In IDLE the search runs on the live command mask so the first lane is
   // known in the accepting cycle; afterwards it runs on the latched mask.
   assign pick_first = (state_q == IDLE);
   assign pick_mask  = pick_first ? lane_mask : mask_q;

   next_lane_pick u_pick (
      .mask      (pick_mask),
      .lane      (lane_q),
      .first     (pick_first),
      .next_lane (pick_lane),
      .valid     (pick_valid)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         base_q  <= '0;
         dest_q  <= '0;
         mask_q  <= '0;
         lane_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  dest_q <= dest_reg;
                  mask_q <= lane_mask;
                  lane_q <= pick_lane;
               end
            end
            WAIT: begin
               if (mem_rvalid) data_q <= mem_rdata;
            end
            WRITE: begin
               if (pick_valid) lane_q <= pick_lane;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d            = state_q;
      mem_req            = 1'b0;
      mem_addr           = '0;
      rf_write_enable    = 1'b0;
      rf_mem_load_enable = 1'b0;
      rf_write_address_r = '0;
      rf_write_address_c = '0;
      rf_write_data      = '0;
      busy               = 1'b0;
      done               = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) state_d = pick_valid ? REQ : DONE;
         end
         REQ: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_addr = lane_addr(base_q, lane_q);
            if (mem_ready) state_d = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (mem_rvalid) state_d = WRITE;
         end
         WRITE: begin
            busy               = 1'b1;
            rf_write_enable    = 1'b1;
            rf_mem_load_enable = 1'b1;
            rf_write_address_r = dest_q;
            rf_write_address_c = lane_q;
            rf_write_data      = {{(VREG_W-LANE_W){1'b0}}, data_q};
            state_d            = pick_valid ? REQ : DONE;
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_vector_load_unit.sv
module tb_vector_load_unit;

   logic         clk;
   logic         reset;
   logic         start;
   logic [31:0]  base_addr;
   logic [3:0]   dest_reg;
   logic [3:0]   lane_mask;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_ready;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         rf_write_enable;
   logic         rf_mem_load_enable;
   logic [3:0]   rf_write_address_r;
   logic [1:0]   rf_write_address_c;
   logic [127:0] rf_write_data;
   logic         busy;
   logic         done;

   vector_load_unit dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .base_addr          (base_addr),
      .dest_reg           (dest_reg),
      .lane_mask          (lane_mask),
      .mem_req            (mem_req),
      .mem_addr           (mem_addr),
      .mem_ready          (mem_ready),
      .mem_rvalid         (mem_rvalid),
      .mem_rdata          (mem_rdata),
      .rf_write_enable    (rf_write_enable),
      .rf_mem_load_enable (rf_mem_load_enable),
      .rf_write_address_r (rf_write_address_r),
      .rf_write_address_c (rf_write_address_c),
      .rf_write_data      (rf_write_data),
      .busy               (busy),
      .done               (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // memory responder configuration (written by tasks only)
   logic [31:0] resp_data [0:7];
   int          rdy_stall [0:7];
   int          rv_delay  [0:7];
   logic        clear_rf = 1'b0;
   logic        man_rvalid = 1'b0;
   logic [31:0] man_rdata = '0;

   // responder outputs and observation logs (written by the model only)
   logic        auto_ready = 1'b0;
   logic        auto_rvalid = 1'b0;
   logic [31:0] auto_rdata = '0;
   int          cyc = 0;
   int          start_cyc = 0;
   int          req_cnt = 0, resp_idx = 0, req_cycles = 0;
   int          stall_cnt = 0, rv_cnt = 0;
   logic        pending = 1'b0, req_open = 1'b0;
   logic [31:0] open_addr = '0;
   int          stable_err = 0, upper_err = 0, mle_err = 0;
   int          wr_cnt = 0, done_cnt = 0, done_cyc = -1, busy_cnt = 0;
   logic [31:0] addr_log [0:7];
   int          wr_cyc   [0:7];
   logic [1:0]  wr_lane  [0:7];
   logic [3:0]  wr_reg   [0:7];
   logic [127:0] rf_model [0:15];

   assign mem_ready  = auto_ready;
   assign mem_rvalid = auto_rvalid | man_rvalid;
   assign mem_rdata  = auto_rvalid ? auto_rdata : man_rdata;

   always @(posedge clk) cyc = cyc + 1;

   // Memory responder plus register-file model, evaluated mid-cycle.
   always @(negedge clk) begin
      auto_ready  = 1'b0;
      auto_rvalid = 1'b0;
      auto_rdata  = '0;
      if (clear_rf) begin
         for (int r = 0; r < 16; r++) rf_model[r] = '0;
      end
      if (!reset) begin
         pending   = 1'b0;
         req_open  = 1'b0;
         stall_cnt = 0;
         rv_cnt    = 0;
      end else begin
         if (start && !busy) begin
            req_cnt = 0; resp_idx = 0; req_cycles = 0; wr_cnt = 0;
            done_cnt = 0; done_cyc = -1; busy_cnt = 0;
            stable_err = 0; upper_err = 0; mle_err = 0;
            start_cyc = cyc;
         end
         if (busy) busy_cnt = busy_cnt + 1;
         if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc - start_cyc;
         end
         if (rf_mem_load_enable !== rf_write_enable) mle_err = mle_err + 1;
         if (rf_write_enable) begin
            if (wr_cnt < 8) begin
               wr_cyc[wr_cnt]  = cyc - start_cyc;
               wr_lane[wr_cnt] = rf_write_address_c;
               wr_reg[wr_cnt]  = rf_write_address_r;
            end
            wr_cnt = wr_cnt + 1;
            if (rf_write_data[127:32] !== 96'd0) upper_err = upper_err + 1;
            rf_model[rf_write_address_r][int'(rf_write_address_c)*32 +: 32] = rf_write_data[31:0];
         end
         if (pending) begin
            if (rv_cnt >= rv_delay[resp_idx]) begin
               auto_rvalid = 1'b1;
               auto_rdata  = resp_data[resp_idx];
               resp_idx    = resp_idx + 1;
               pending     = 1'b0;
               rv_cnt      = 0;
            end else begin
               rv_cnt = rv_cnt + 1;
            end
         end else if (mem_req) begin
            req_cycles = req_cycles + 1;
            if (!req_open) begin
               req_open  = 1'b1;
               open_addr = mem_addr;
            end else if (mem_addr !== open_addr) begin
               stable_err = stable_err + 1;
            end
            if (stall_cnt >= rdy_stall[req_cnt]) begin
               auto_ready        = 1'b1;
               addr_log[req_cnt] = mem_addr;
               req_cnt           = req_cnt + 1;
               req_open          = 1'b0;
               stall_cnt         = 0;
               pending           = 1'b1;
            end else begin
               stall_cnt = stall_cnt + 1;
            end
         end
      end
   end

   task automatic setup_mem(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
      for (int i = 0; i < 8; i++) begin
         rdy_stall[i] = 0;
         rv_delay[i]  = 0;
         resp_data[i] = 32'hEEEE_0000 + i;
      end
      resp_data[0] = d0; resp_data[1] = d1; resp_data[2] = d2; resp_data[3] = d3;
   endtask

   // Called at posedge+1; start is seen high during the current cycle (cycle 0).
   task automatic do_start(input logic [31:0] base, input logic [3:0] dst,
                           input logic [3:0] msk);
      start = 1'b1; base_addr = base; dest_reg = dst; lane_mask = msk;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 32'hDEAD_BEEF; dest_reg = 4'hF; lane_mask = 4'hF;
   endtask

   task automatic wait_done(output bit ok);
      for (int i = 0; i < 200 && done_cnt == 0; i++) @(posedge clk);
      #1;
      ok = (done_cnt != 0);
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; base_addr = '0; dest_reg = '0; lane_mask = '0;
      clear_rf = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({mem_req, busy, done, rf_write_enable, rf_mem_load_enable} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {mem_req, busy, done, rf_write_enable, rf_mem_load_enable});
      end
      tests_run++;
      if ({mem_addr, rf_write_address_r, rf_write_address_c, rf_write_data} !== '0) begin
         tests_failed++;
         $display("FAIL reset_buses: addr %h ar %h ac %h data %h want 0",
                  mem_addr, rf_write_address_r, rf_write_address_c, rf_write_data);
      end
      clear_rf = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_mask;
      bit ok;
      setup_mem(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      do_start(32'h100, 4'd5, 4'b1111);
      wait_done(ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL full_timeout: done never seen"); end
      tests_run++;
      if (done_cyc !== 13) begin tests_failed++; $display("FAIL full_done_cycle: got %0d want 13", done_cyc); end
      tests_run++;
      if (wr_cnt !== 4) begin tests_failed++; $display("FAIL full_wr_count: got %0d want 4", wr_cnt); end
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (wr_cyc[k] !== 3 + 3 * k || wr_lane[k] !== 2'(k) || wr_reg[k] !== 4'd5) begin
            tests_failed++;
            $display("FAIL full_write%0d: cyc %0d lane %0d reg %0d want %0d %0d 5",
                     k, wr_cyc[k], wr_lane[k], wr_reg[k], 3 + 3 * k, k);
         end
         tests_run++;
         if (addr_log[k] !== 32'h100 + 32'(4 * k)) begin
            tests_failed++;
            $display("FAIL full_addr%0d: got %h want %h", k, addr_log[k], 32'h100 + 32'(4 * k));
         end
      end
      tests_run++;
      if (rf_model[5] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         tests_failed++;
         $display("FAIL full_reg5: got %h want 000000a3000000a2000000a1000000a0", rf_model[5]);
      end
      tests_run++;
      if (busy_cnt !== 13) begin tests_failed++; $display("FAIL full_busy_cycles: got %0d want 13", busy_cnt); end
      tests_run++;
      if (upper_err !== 0 || mle_err !== 0) begin
         tests_failed++;
         $display("FAIL full_rf_path: upper_err %0d mle_err %0d want 0 0", upper_err, mle_err);
      end
      tests_run++;
      if (busy !== 1'b0) begin tests_failed++; $display("FAIL full_idle_after: busy %b want 0", busy); end
   endtask

   // Issued in the cycle right after DONE, exercising immediate re-acceptance.
   task automatic test_back_to_back_zero_mask;
      bit ok;
      setup_mem(32'h0, 32'h0, 32'h0, 32'h0);
      do_start(32'h900, 4'd6, 4'b0000);
      wait_done(ok);
      tests_run++;
      if (!ok || done_cyc !== 1) begin
         tests_failed++;
         $display("FAIL zero_done_cycle: ok %0d got %0d want 1", ok, done_cyc);
      end
      tests_run++;
      if (req_cycles !== 0 || wr_cnt !== 0) begin
         tests_failed++;
         $display("FAIL zero_no_activity: req_cycles %0d writes %0d want 0 0", req_cycles, wr_cnt);
      end
      tests_run++;
      if (busy_cnt !== 1) begin tests_failed++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
   endtask

   task automatic test_sparse_mask;
      bit ok;
      setup_mem(32'hB1, 32'hB3, 32'h0, 32'h0);
      do_start(32'h200, 4'd5, 4'b1010);
      wait_done(ok);
      tests_run++;
      if (!ok || done_cyc !== 7) begin
         tests_failed++;
         $display("FAIL sparse_done_cycle: ok %0d got %0d want 7", ok, done_cyc);
      end
      tests_run++;
      if (req_cnt !== 2 || addr_log[0] !== 32'h204 || addr_log[1] !== 32'h20C) begin
         tests_failed++;
         $display("FAIL sparse_addrs: n %0d a0 %h a1 %h want 2 204 20c", req_cnt, addr_log[0], addr_log[1]);
      end
      tests_run++;
      if (wr_cnt !== 2 || wr_lane[0] !== 2'd1 || wr_lane[1] !== 2'd3 ||
          wr_cyc[0] !== 3 || wr_cyc[1] !== 6) begin
         tests_failed++;
         $display("FAIL sparse_writes: n %0d lanes %0d %0d cycles %0d %0d want 2 1 3 3 6",
                  wr_cnt, wr_lane[0], wr_lane[1], wr_cyc[0], wr_cyc[1]);
      end
      tests_run++;
      if (rf_model[5] !== 128'h000000B3_000000A2_000000B1_000000A0) begin
         tests_failed++;
         $display("FAIL sparse_reg5: got %h want 000000b3000000a2000000b1000000a0", rf_model[5]);
      end
   endtask

   task automatic test_stall;
      bit ok;
      setup_mem(32'h11, 32'h22, 32'h33, 32'h44);
      rdy_stall[0] = 3;
      rv_delay[0]  = 2;
      do_start(32'h400, 4'd7, 4'b1111);
      wait_done(ok);
      tests_run++;
      if (!ok || done_cyc !== 18) begin
         tests_failed++;
         $display("FAIL stall_done_cycle: ok %0d got %0d want 18", ok, done_cyc);
      end
      tests_run++;
      if (wr_cyc[0] !== 8 || wr_cyc[3] !== 17) begin
         tests_failed++;
         $display("FAIL stall_write_cycles: first %0d last %0d want 8 17", wr_cyc[0], wr_cyc[3]);
      end
      tests_run++;
      if (stable_err !== 0 || req_cycles !== 7 || addr_log[0] !== 32'h400) begin
         tests_failed++;
         $display("FAIL stall_req_hold: unstable %0d req_cycles %0d addr %h want 0 7 400",
                  stable_err, req_cycles, addr_log[0]);
      end
      tests_run++;
      if (rf_model[7] !== 128'h00000044_00000033_00000022_00000011) begin
         tests_failed++;
         $display("FAIL stall_reg7: got %h want 00000044000000330000002200000011", rf_model[7]);
      end
   endtask

   task automatic test_wrap;
      bit ok;
      setup_mem(32'h1, 32'h2, 32'h3, 32'h4);
      do_start(32'hFFFF_FFFC, 4'd2, 4'b1111);
      wait_done(ok);
      tests_run++;
      if (!ok || done_cyc !== 13) begin
         tests_failed++;
         $display("FAIL wrap_done_cycle: ok %0d got %0d want 13", ok, done_cyc);
      end
      tests_run++;
      if (addr_log[0] !== 32'hFFFF_FFFC || addr_log[1] !== 32'h0 ||
          addr_log[2] !== 32'h4 || addr_log[3] !== 32'h8) begin
         tests_failed++;
         $display("FAIL wrap_addrs: got %h %h %h %h want fffffffc 0 4 8",
                  addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
      end
   endtask

   task automatic test_reset_midflight;
      bit ok;
      setup_mem(32'h51, 32'h52, 32'h53, 32'h54);
      rv_delay[2] = 20;
      do_start(32'h300, 4'd3, 4'b1111);
      for (int i = 0; i < 50 && req_cnt < 3; i++) @(posedge clk);
      #1;
      tests_run++;
      if (req_cnt !== 3) begin tests_failed++; $display("FAIL mid_reach_lane2: req_cnt %0d want 3", req_cnt); end
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      tests_run++;
      if ({mem_req, busy, done, rf_write_enable, rf_mem_load_enable} !== 5'b0 ||
          mem_addr !== '0 || rf_write_data !== '0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: ctrl %b addr %h data %h want 0",
                  {mem_req, busy, done, rf_write_enable, rf_mem_load_enable}, mem_addr, rf_write_data);
      end
      @(posedge clk); #1;
      man_rvalid = 1'b1; man_rdata = 32'hDEAD_DEAD;
      @(posedge clk); #1;
      man_rvalid = 1'b0; man_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if (wr_cnt !== 2 || busy !== 1'b0 ||
          rf_model[3] !== 128'h00000000_00000000_00000052_00000051) begin
         tests_failed++;
         $display("FAIL mid_late_rvalid: writes %0d busy %b reg3 %h want 2 0 00000000000000000000005200000051",
                  wr_cnt, busy, rf_model[3]);
      end
      setup_mem(32'hC0, 32'hC1, 32'hC2, 32'hC3);
      do_start(32'h500, 4'd9, 4'b1111);
      wait_done(ok);
      tests_run++;
      if (!ok || done_cyc !== 13 ||
          rf_model[9] !== 128'h000000C3_000000C2_000000C1_000000C0) begin
         tests_failed++;
         $display("FAIL mid_restart: ok %0d done %0d reg9 %h want 1 13 000000c3000000c2000000c1000000c0",
                  ok, done_cyc, rf_model[9]);
      end
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_back_to_back_zero_mask();
      test_sparse_mask();
      test_stall();
      test_wrap();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
